// File: rtl/voice_mixer_pkg.sv
// rtl/voice_mixer_pkg.sv - shared audio constants, offset-binary conversion and mixer state enum
package voice_mixer_pkg;

    localparam int AUDIO_BITDEPTH  = 14;
    localparam int AUDIO_VOL_BITS  = 4;
    localparam int AUDIO_VOL_SHIFT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } mix_state_e;

    // Offset-binary <-> two's complement is the same operation in both
    // directions: flip the MSB of a `bits`-wide value.
    function automatic logic [31:0] ob_flip(input logic [31:0] x, input int bits);
        return x ^ (32'd1 << (bits - 1));
    endfunction

endpackage

// File: rtl/voice_mixer_pdm_modulator.sv
// rtl/voice_mixer_pdm_modulator.sv - first-order sigma-delta PDM modulator
// Ports: clk, rst (sync, active-high), in (offset-binary sample), pdm_out (1-bit stream).
module pdm_modulator #(
    parameter int BITDEPTH = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITDEPTH-1:0] in,
    output logic                pdm_out
);

    logic [BITDEPTH:0] pacc_q, pacc_d;
    logic              pdm_q, pdm_d;

    always_comb begin
        // The carry out of the previous add is the output bit; it is
        // dropped from the accumulator before the next add.
        pacc_d = {1'b0, pacc_q[BITDEPTH-1:0]} + {1'b0, in};
        pdm_d  = pacc_q[BITDEPTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pacc_q <= '0;
            pdm_q  <= 1'b0;
        end else begin
            pacc_q <= pacc_d;
            pdm_q  <= pdm_d;
        end
    end

    assign pdm_out = pdm_q;

endmodule

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - time-multiplexed volume-scaled saturating voice mixer
// Ports: clk, rst (sync, active-high), sample_clock (rising edge starts a mix),
//        voices_in / volumes (voice 0 in LSBs), out (offset-binary), out_valid (1-cycle pulse),
//        overrun (sticky, cleared by rst), pdm_out (PDM stream).
// Optional feature: define VOICE_MIXER_PDM_EN to drive pdm_out from a sigma-delta modulator;
// otherwise pdm_out is tied to 0.
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int BITDEPTH   = AUDIO_BITDEPTH,
    parameter int NUM_VOICES = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sample_clock,
    input  logic [NUM_VOICES*BITDEPTH-1:0]       voices_in,
    input  logic [NUM_VOICES*AUDIO_VOL_BITS-1:0] volumes,
    output logic [BITDEPTH-1:0]                  out,
    output logic                                 out_valid,
    output logic                                 overrun,
    output logic                                 pdm_out
);

    localparam int PROD_W = BITDEPTH + AUDIO_VOL_BITS + 1;
    // Headroom of clog2(NUM_VOICES) bits means the sum can never wrap.
    localparam int ACC_W  = PROD_W + $clog2(NUM_VOICES);
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (BITDEPTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-(1 << (BITDEPTH - 1)));
    localparam logic [BITDEPTH-1:0]     MIDPOINT = BITDEPTH'(1 << (BITDEPTH - 1));
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);

    mix_state_e                           state_q, state_d;
    logic                                 sc_q, sc_d;
    logic [NUM_VOICES*BITDEPTH-1:0]       voices_q, voices_d;
    logic [NUM_VOICES*AUDIO_VOL_BITS-1:0] volumes_q, volumes_d;
    logic signed [ACC_W-1:0]              acc_q, acc_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [BITDEPTH-1:0]                  out_q, out_d;
    logic                                 out_valid_q, out_valid_d;
    logic                                 overrun_q, overrun_d;

    logic                                 tick;
    logic [BITDEPTH-1:0]                  cur_voice;
    logic [AUDIO_VOL_BITS-1:0]            cur_vol;
    logic signed [BITDEPTH-1:0]           voice_s;
    logic signed [PROD_W-1:0]             prod;
    logic signed [ACC_W-1:0]              shifted;
    logic signed [ACC_W-1:0]              sat;

    assign tick = sample_clock & ~sc_q;

    // Shared multiply-accumulate datapath, one voice per cycle.
    always_comb begin
        cur_voice = voices_q[int'(idx_q)*BITDEPTH +: BITDEPTH];
        cur_vol   = volumes_q[int'(idx_q)*AUDIO_VOL_BITS +: AUDIO_VOL_BITS];
        voice_s   = BITDEPTH'(ob_flip(32'(cur_voice), BITDEPTH));
        // Volume is unsigned; the zero-extended operand keeps the product signed.
        prod      = PROD_W'(voice_s) * PROD_W'($signed({1'b0, cur_vol}));
        // Arithmetic shift floors toward -inf; this is the only truncation.
        shifted   = acc_q >>> AUDIO_VOL_SHIFT;
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN;
        end else begin
            sat = shifted;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (tick) state_d = ST_ACCUM;
            ST_ACCUM:  if (idx_q == LAST_IDX) state_d = ST_OUTPUT;
            ST_OUTPUT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output and datapath register updates.
    always_comb begin
        sc_d        = sample_clock;
        voices_d    = voices_q;
        volumes_d   = volumes_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        // A new edge while busy (including the OUTPUT cycle) is dropped, not queued.
        overrun_d   = overrun_q | (tick & (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    voices_d  = voices_in;
                    volumes_d = volumes;
                    acc_d     = '0;
                    idx_d     = '0;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + ACC_W'(prod);
                idx_d = idx_q + IDX_W'(1);
            end
            ST_OUTPUT: begin
                out_d       = BITDEPTH'(ob_flip(32'(sat), BITDEPTH));
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sc_q        <= 1'b0;
            voices_q    <= '0;
            volumes_q   <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_q       <= MIDPOINT;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sc_q        <= sc_d;
            voices_q    <= voices_d;
            volumes_q   <= volumes_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

`ifdef VOICE_MIXER_PDM_EN
    pdm_modulator #(
        .BITDEPTH(BITDEPTH)
    ) u_pdm (
        .clk    (clk),
        .rst    (rst),
        .in     (out_q),
        .pdm_out(pdm_out)
    );
`else
    assign pdm_out = 1'b0;
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// tb/tb_voice_mixer.sv - scoreboard bench for voice_mixer
module tb_voice_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_clock;
    logic [55:0] voices_in;
    logic [15:0] volumes;
    logic [13:0] out;
    logic        out_valid;
    logic        overrun;
    logic        pdm_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [13:0] val;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    voice_mixer dut (
        .clk         (clk),
        .rst         (rst),
        .sample_clock(sample_clock),
        .voices_in   (voices_in),
        .volumes     (volumes),
        .out         (out),
        .out_valid   (out_valid),
        .overrun     (overrun),
        .pdm_out     (pdm_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: every out_valid pulse must match the oldest expected mix,
    // both in value and in the cycle it appears.
    always @(negedge clk) begin
        if (out_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out_valid: out=%h at cyc %0d, no mix pending", out, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (out !== mon_e.val || cyc != mon_e.at) begin
                    n_err++;
                    $display("FAIL mix_result: out=%h cyc=%0d, expected out=%h cyc=%0d",
                             out, cyc, mon_e.val, mon_e.at);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Latch edge E0 is the next posedge; out lands at E5.
    task automatic mix(input logic [55:0] v, input logic [15:0] vol, input logic [13:0] e);
        @(negedge clk);
        voices_in    = v;
        volumes      = vol;
        sample_clock = 1'b1;
        sb.push_back('{e, cyc + 6});
        @(negedge clk);
        voices_in    = ~v;
        volumes      = ~vol;
        sample_clock = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    int ones;
    int exp_ones;

    initial begin
        rst          = 1'b1;
        sample_clock = 1'b0;
        voices_in    = '0;
        volumes      = '0;
        repeat (3) @(negedge clk);
        check("reset_out", 32'(out), 32'h2000);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_overrun", 32'(overrun), 0);
        check("reset_pdm_out", 32'(pdm_out), 0);
        rst = 1'b0;

        mix(56'({$urandom(), $urandom()}), 16'h0000, 14'h2000);
        mix({14'h0000, 14'h0000, 14'h0000, 14'h3FFF}, 16'h000F, 14'h3DFF);
        mix({4{14'h3FFF}}, 16'hFFFF, 14'h3FFF);
        mix(56'h0, 16'hFFFF, 14'h0000);
        mix({14'h0000, 14'h0000, 14'h0000, 14'h1FFF}, 16'h0001, 14'h1FFF);
        mix({14'h2000, 14'h2010, 14'h1F00, 14'h2100}, {4'd7, 4'd15, 4'd1, 4'd3}, 14'h202F);

        // Second rising edge two clocks after the first: dropped, flagged.
        @(negedge clk);
        voices_in    = {14'h0000, 14'h0000, 14'h0000, 14'h3FFF};
        volumes      = 16'h000F;
        sample_clock = 1'b1;
        sb.push_back('{14'h3DFF, cyc + 6});
        @(negedge clk);
        sample_clock = 1'b0;
        voices_in    = '0;
        @(negedge clk);
        sample_clock = 1'b1;
        @(negedge clk);
        sample_clock = 1'b0;
        check("overrun_set", 32'(overrun), 1);
        repeat (8) @(negedge clk);
        check("overrun_sticky", 32'(overrun), 1);
        check("overrun_out_kept", 32'(out), 32'h3DFF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("overrun_cleared", 32'(overrun), 0);

        // sample_clock held high must produce exactly one mix.
        @(negedge clk);
        voices_in    = {14'h0000, 14'h0000, 14'h0000, 14'h2100};
        volumes      = 16'h000F;
        sample_clock = 1'b1;
        sb.push_back('{14'h20F0, cyc + 6});
        repeat (20) @(negedge clk);
        sample_clock = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during ACCUM aborts the mix.
        @(negedge clk);
        voices_in    = {14'h0000, 14'h0000, 14'h0000, 14'h3FFF};
        volumes      = 16'h000F;
        sample_clock = 1'b1;
        @(negedge clk);
        sample_clock = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_midpoint", 32'(out), 32'h2000);
        check("abort_no_valid", 32'(out_valid), 0);
        repeat (8) @(negedge clk);
        mix({14'h0000, 14'h0000, 14'h0000, 14'h3FFF}, 16'h000F, 14'h3DFF);

        // Hold out at 0x3000 and count PDM ones over 1024 clocks.
        mix({14'h0000, 14'h0000, 14'h2008, 14'h3FFF}, 16'h0018, 14'h3000);
        ones = 0;
        repeat (1024) begin
            @(negedge clk);
            if (pdm_out) ones++;
        end
`ifdef VOICE_MIXER_PDM_EN
        exp_ones = 768;
`else
        exp_ones = 0;
`endif
        check("pdm_ones", 32'(ones), 32'(exp_ones));

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
